// File: rtl/prog_loader.sv
// Program-memory loader: assembles big-endian 32-bit words from a byte stream and
// writes them from address 0 upward. Optional checksum stage: PROG_LOADER_CSUM_EN.
`timescale 1ns/1ps

module prog_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned WORD_W = 32
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [WORD_W-1:0] pm_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] word_count
);

    localparam int unsigned SHIFT_W = WORD_W - 8;

`ifdef PROG_LOADER_CSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE} state_e;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE} state_e;
`endif

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [SHIFT_W-1:0]  word_q, word_d;
    logic                ready_q, ready_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
`ifdef PROG_LOADER_CSUM_EN
    logic [7:0]          csum_q, csum_d;
    logic                err_q, err_d;
`endif
    logic                xfer_c;
    logic [ADDR_W-1:0]   len_in_c;

    assign xfer_c   = byte_valid & ready_q;
    assign len_in_c = ADDR_W'(byte_in);

    // Next-state and next-output computation
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        count_d = count_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef PROG_LOADER_CSUM_EN
        csum_d  = csum_q;
        err_d   = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LEN;
                    idx_d   = '0;
                    count_d = '0;
                    bcnt_d  = 2'd0;
`ifdef PROG_LOADER_CSUM_EN
                    csum_d  = 8'h00;
                    err_d   = 1'b0;
`endif
                end
            end
            S_LEN: begin
                if (xfer_c) begin
                    len_d  = len_in_c;
                    bcnt_d = 2'd0;
`ifdef PROG_LOADER_CSUM_EN
                    csum_d = csum_q ^ byte_in;
                    state_d = (len_in_c == '0) ? S_CSUM : S_DATA;
`else
                    state_d = (len_in_c == '0) ? S_DONE : S_DATA;
`endif
                end
            end
            S_DATA: begin
                if (xfer_c) begin
                    word_d = {word_q[SHIFT_W-9:0], byte_in};
                    bcnt_d = bcnt_q + 2'd1;
`ifdef PROG_LOADER_CSUM_EN
                    csum_d = csum_q ^ byte_in;
`endif
                    if (bcnt_q == 2'd3) begin
                        state_d = S_WRITE;
                        addr_d  = idx_q;
                        wdata_d = {word_q, byte_in};
                    end
                end
            end
            S_WRITE: begin
                idx_d   = idx_q + ADDR_W'(1);
                count_d = count_q + ADDR_W'(1);
                if (idx_d == len_q) begin
`ifdef PROG_LOADER_CSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef PROG_LOADER_CSUM_EN
            S_CSUM: begin
                if (xfer_c) begin
                    err_d   = (byte_in != csum_q);
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered outputs are a function of the state being entered
`ifdef PROG_LOADER_CSUM_EN
        ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
        hold_d  = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_WRITE) ||
                  (state_d == S_CSUM);
`else
        ready_d = (state_d == S_LEN) || (state_d == S_DATA);
        hold_d  = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_WRITE);
`endif
        we_d    = (state_d == S_WRITE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
            bcnt_q  <= 2'd0;
            word_q  <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
            csum_q  <= 8'h00;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
`ifdef PROG_LOADER_CSUM_EN
            csum_q  <= csum_d;
            err_q   <= err_d;
`endif
        end
    end

    assign byte_ready = ready_q;
    assign pm_we      = we_q;
    assign pm_addr    = addr_q;
    assign pm_wdata   = wdata_q;
    assign cpu_hold   = hold_q;
    assign done       = done_q;
    assign word_count = count_q;
`ifdef PROG_LOADER_CSUM_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule
